unary_stream_decoder: RTL and testbench
=======================================

# unary_stream_decoder

Consumes one unary bitstream, as produced by the unary arithmetic units (`y`/`valid`), and converts it back to binary. It counts ones over a frame of `INPUT_WIDTH` valid bits and presents the binary result through a ready/valid handshake. While the frame is in progress it publishes running lower/upper bounds and an early-settle flag, matching the bound semantics the upstream units use for progressive output. It sits at the tail of every unary datapath, feeding binary consumers and test scoreboards.

## Interface
- `INPUT_WIDTH`, 32, bits per unary frame (≥1).
- `COUNT_WIDTH`, `$clog2(INPUT_WIDTH+1)`, width of all count/bound outputs.
- `EPSILON`, 0, early-settle tolerance in ones (0 ≤ EPSILON ≤ INPUT_WIDTH).
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-low; sampled on posedge `clk`.
- `stream_bit` in 1: unary data bit, qualified by `stream_valid`.
- `stream_valid` in 1: `stream_bit` is a frame bit this cycle. There is no backpressure upstream.
- `result_ready` in 1: consumer accepts `result`.
- `result` out COUNT_WIDTH: binary count of ones of the last completed frame.
- `result_valid` out 1: `result` holds an unaccepted frame.
- `lower_bound` out COUNT_WIDTH: ones seen so far in the current frame.
- `upper_bound` out COUNT_WIDTH: `lower_bound + (INPUT_WIDTH − bits_seen)`.
- `estimate` out COUNT_WIDTH: `(lower_bound + upper_bound) >> 1`, rounded down.
- `early_settled` out 1: in COLLECT and `upper_bound − lower_bound ≤ EPSILON`.
- `bits_seen` out COUNT_WIDTH: valid bits consumed in the current frame.
- `busy` out 1: state ≠ IDLE.
- `dropped` out 1: sticky flag; a valid bit was discarded.

## Operation
- The FSM has three states: IDLE, COLLECT and HOLD.
- **IDLE:**
  - On `stream_valid`, the bit is counted: `bits_seen` becomes 1 and `lower_bound` becomes `stream_bit`.
  - Next state is COLLECT. If INPUT_WIDTH==1, next state is HOLD instead.
- **COLLECT:**
  - On each `stream_valid`, `bits_seen` increments and `lower_bound` increments by `stream_bit`.
  - When the accepted bit brings `bits_seen` to INPUT_WIDTH:
    - `result` ← final `lower_bound`.
    - `result_valid` ← 1.
    - Go to HOLD.
  - Cycles with `stream_valid` low are gaps. They are ignored and state is held.
- **HOLD:**
  - `result`/`result_valid` are held stable until `result_ready`.
  - `result_ready` alone:
    - `result_valid` ← 0.
    - Counters clear: `bits_seen`=0, `lower_bound`=0.
    - Go to IDLE.
  - `result_ready` and `stream_valid` in the same cycle:
    - The frame is handed off.
    - The bit starts the next frame: `bits_seen`=1, `lower_bound`=`stream_bit`.
    - Go to COLLECT, or stay in HOLD with the new result if INPUT_WIDTH==1.
  - `stream_valid` without `result_ready`: the bit is discarded and `dropped` ← 1.
  - HOLD counters keep the completed frame's values: `bits_seen`=INPUT_WIDTH and bounds equal.
- `dropped` clears only on reset.
- **Arithmetic:**
  - All counts are unsigned COUNT_WIDTH and never exceed INPUT_WIDTH.
  - `estimate` is computed at COUNT_WIDTH+1 bits, then truncated after the shift.
- `early_settled` is combinational from registered state and is 0 outside COLLECT.

## Timing
- All outputs except `upper_bound`, `estimate` and `early_settled` are registered. Those three are combinational from registers.
- **Latency:** `result_valid` rises the cycle after the posedge that samples the final frame bit.
- **Handshake:**
  - The transfer occurs on the posedge where `result_valid && result_ready`.
  - `result_ready` while `result_valid`=0 has no effect.
- **Throughput:** one bit per cycle. A zero-bubble frame sequence is supported when `result_ready` is held high.
- **Reset values:**
  - All zero: `result`, `result_valid`, `lower_bound`, `bits_seen`, `busy`, `dropped`, `early_settled`.
  - `upper_bound` = INPUT_WIDTH.
  - `estimate` = INPUT_WIDTH>>1.
  - State = IDLE.
- **Reset mid-frame or in HOLD:** the partial frame or pending result is discarded, with no output pulse. Reset wins over every simultaneous input.

## Structure
- Shared package `unary_pkg` holds:
  - the `unary_dec_state_t` enum {IDLE, COLLECT, HOLD};
  - the count-width helper function, so adder and decoder derive widths identically.
- Natural sub-module: `unary_bound_tracker`. It holds the `bits_seen`/`lower_bound` counters with clear/load/increment controls, plus the combinational `upper_bound`, `estimate` and `early_settled`. The same tracker is reusable in other unary units.
- The FSM and result register live in the top module.

## Test plan
All scenarios use INPUT_WIDTH=8 and EPSILON=2.

1. **All-ones frame:** 8 valid cycles of bit 1, `result_ready`=1 → `result`=8 with `result_valid` one cycle after the 8th bit; upper=lower=8 in HOLD.
2. **Gapped frame:** pattern 1,0,1,1,0,0,1,0 with `stream_valid` low on alternate cycles → `result`=4. After 6 bits (lower=3, upper=5), `early_settled`=1 and `estimate`=4.
3. **Back-to-back frames:**
   - Stimulus: two frames with no gap, `result_ready` held high, the second frame's first bit coinciding with the accept.
   - Response: results 8 then 0, no bit lost, `dropped`=0.
4. **Backpressure:** `result_ready`=0 for 3 cycles after completion with `stream_valid`=1 → `result` held stable, `dropped`=1. The next frame starts after the accept.
5. **Reset mid-frame:** assert `reset` low after 5 bits → next cycle `bits_seen`=0, `upper_bound`=8, state IDLE. A following 8-bit frame decodes correctly.
6. **Early-settle boundary:** after 5 bits (range 3), `early_settled`=0; after 6 bits (range 2), `early_settled`=1; in HOLD, `early_settled`=0.

Source files
------------

// File: rtl/unary_pkg.sv
// Shared types and width helpers for the unary arithmetic units.
package unary_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } unary_dec_state_t;

  // Bits needed to hold a count in 0..n.
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/unary_bound_tracker.sv
// Ones/bit counters for a unary frame plus the progressive bounds derived from them.
module unary_bound_tracker
  import unary_pkg::*;
#(
  parameter  int unsigned INPUT_WIDTH = 32,
  parameter  int unsigned EPSILON     = 0,
  localparam int unsigned CW          = count_width(INPUT_WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_load,
  input  logic          i_inc,
  input  logic          i_bit,
  input  logic          i_collect,
  output logic [CW-1:0] o_bits_seen,
  output logic [CW-1:0] o_lower_bound,
  output logic [CW-1:0] o_upper_bound_c,
  output logic [CW-1:0] o_estimate_c,
  output logic          o_early_settled_c
);

  logic [CW-1:0] r_bits;
  logic [CW-1:0] r_lower;
  logic [CW-1:0] w_remaining;
  logic [CW-1:0] w_upper;
  logic [CW:0]   w_sum;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bits  <= '0;
      r_lower <= '0;
    end else if (i_clear) begin
      r_bits  <= '0;
      r_lower <= '0;
    end else if (i_load) begin
      r_bits  <= CW'(1);
      r_lower <= CW'(i_bit);
    end else if (i_inc) begin
      r_bits  <= r_bits + CW'(1);
      r_lower <= r_lower + CW'(i_bit);
    end
  end

  // Unseen bits could all still be ones, so they widen the upper bound.
  always_comb begin
    w_remaining = CW'(INPUT_WIDTH) - r_bits;
    w_upper     = r_lower + w_remaining;
    w_sum       = {1'b0, r_lower} + {1'b0, w_upper};
  end

  assign o_bits_seen       = r_bits;
  assign o_lower_bound     = r_lower;
  assign o_upper_bound_c   = w_upper;
  assign o_estimate_c      = w_sum[CW:1];
  assign o_early_settled_c = i_collect && (w_remaining <= CW'(EPSILON));

endmodule

// File: rtl/unary_stream_decoder.sv
// Converts a unary bitstream frame back to a binary count behind a ready/valid handshake.
module unary_stream_decoder
  import unary_pkg::*;
#(
  parameter  int unsigned INPUT_WIDTH = 32,
  parameter  int unsigned EPSILON     = 0,
  localparam int unsigned COUNT_WIDTH = count_width(INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stream_bit,
  input  logic                   stream_valid,
  input  logic                   result_ready,
  output logic [COUNT_WIDTH-1:0] result,
  output logic                   result_valid,
  output logic [COUNT_WIDTH-1:0] lower_bound,
  output logic [COUNT_WIDTH-1:0] upper_bound,
  output logic [COUNT_WIDTH-1:0] estimate,
  output logic                   early_settled,
  output logic [COUNT_WIDTH-1:0] bits_seen,
  output logic                   busy,
  output logic                   dropped
);

  localparam int unsigned CW = COUNT_WIDTH;

  unary_dec_state_t r_state;
  unary_dec_state_t w_next;
  logic [CW-1:0]    r_result;
  logic             r_result_valid;
  logic             r_dropped;
  logic             r_busy;

  logic             w_clear;
  logic             w_load;
  logic             w_inc;
  logic             w_res_load;
  logic             w_res_clr;
  logic             w_drop;
  logic [CW-1:0]    w_res_val;
  logic [CW-1:0]    w_bits;
  logic [CW-1:0]    w_lower;

  unary_bound_tracker #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .EPSILON     (EPSILON)
  ) u_tracker (
    .clk               (clk),
    .reset             (reset),
    .i_clear           (w_clear),
    .i_load            (w_load),
    .i_inc             (w_inc),
    .i_bit             (stream_bit),
    .i_collect         (r_state == COLLECT),
    .o_bits_seen       (w_bits),
    .o_lower_bound     (w_lower),
    .o_upper_bound_c   (upper_bound),
    .o_estimate_c      (estimate),
    .o_early_settled_c (early_settled)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_dropped      <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      if (w_res_load) begin
        r_result       <= w_res_val;
        r_result_valid <= 1'b1;
      end else if (w_res_clr) begin
        r_result_valid <= 1'b0;
      end
      if (w_drop) r_dropped <= 1'b1;
    end
  end

  // A single-bit frame completes on the same bit that starts it.
  always_comb begin
    w_next     = r_state;
    w_clear    = 1'b0;
    w_load     = 1'b0;
    w_inc      = 1'b0;
    w_res_load = 1'b0;
    w_res_clr  = 1'b0;
    w_drop     = 1'b0;
    w_res_val  = r_result;
    case (r_state)
      IDLE: begin
        if (stream_valid) begin
          w_load = 1'b1;
          if (INPUT_WIDTH == 1) begin
            w_next     = HOLD;
            w_res_load = 1'b1;
            w_res_val  = CW'(stream_bit);
          end else begin
            w_next = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (stream_valid) begin
          w_inc = 1'b1;
          if (w_bits == CW'(INPUT_WIDTH - 1)) begin
            w_next     = HOLD;
            w_res_load = 1'b1;
            w_res_val  = w_lower + CW'(stream_bit);
          end
        end
      end
      HOLD: begin
        if (result_ready && stream_valid) begin
          w_load = 1'b1;
          if (INPUT_WIDTH == 1) begin
            w_res_load = 1'b1;
            w_res_val  = CW'(stream_bit);
          end else begin
            w_res_clr = 1'b1;
            w_next    = COLLECT;
          end
        end else if (result_ready) begin
          w_clear   = 1'b1;
          w_res_clr = 1'b1;
          w_next    = IDLE;
        end else if (stream_valid) begin
          w_drop = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign lower_bound  = w_lower;
  assign bits_seen    = w_bits;
  assign busy         = r_busy;
  assign dropped      = r_dropped;

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Randomised and directed bench for unary_stream_decoder against a frame-queue model.
module tb_unary_stream_decoder;

  localparam int unsigned IW  = 8;
  localparam int unsigned EPS = 2;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stream_bit = 1'b0;
  logic          stream_valid = 1'b0;
  logic          result_ready = 1'b0;
  logic [CW-1:0] result;
  logic          result_valid;
  logic [CW-1:0] lower_bound;
  logic [CW-1:0] upper_bound;
  logic [CW-1:0] estimate;
  logic          early_settled;
  logic [CW-1:0] bits_seen;
  logic          busy;
  logic          dropped;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: bits of the frame in flight, plus a pending completed result.
  logic m_frame[$];
  bit   m_pending = 1'b0;
  int   m_result  = 0;
  bit   m_dropped = 1'b0;

  unary_stream_decoder #(
    .INPUT_WIDTH (IW),
    .EPSILON     (EPS)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .stream_bit    (stream_bit),
    .stream_valid  (stream_valid),
    .result_ready  (result_ready),
    .result        (result),
    .result_valid  (result_valid),
    .lower_bound   (lower_bound),
    .upper_bound   (upper_bound),
    .estimate      (estimate),
    .early_settled (early_settled),
    .bits_seen     (bits_seen),
    .busy          (busy),
    .dropped       (dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_ones();
    int n = 0;
    foreach (m_frame[i]) n += int'(m_frame[i]);
    return n;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_frame.delete();
      m_pending = 1'b0;
      m_result  = 0;
      m_dropped = 1'b0;
    end else if (m_pending) begin
      if (result_ready) begin
        m_pending = 1'b0;
        m_frame.delete();
        if (stream_valid) m_frame.push_back(stream_bit);
      end else if (stream_valid) begin
        m_dropped = 1'b1;
      end
    end else if (stream_valid) begin
      m_frame.push_back(stream_bit);
      if (m_frame.size() == IW) begin
        m_result  = m_ones();
        m_pending = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int lo, hi, seen;
      seen = m_frame.size();
      lo   = m_ones();
      hi   = lo + int'(IW) - seen;
      chk("result",        result,        m_result);
      chk("result_valid",  result_valid,  int'(m_pending));
      chk("bits_seen",     bits_seen,     seen);
      chk("lower_bound",   lower_bound,   lo);
      chk("upper_bound",   upper_bound,   hi);
      chk("estimate",      estimate,      (lo + hi) / 2);
      chk("busy",          busy,          int'(m_pending || seen > 0));
      chk("dropped",       dropped,       int'(m_dropped));
      chk("early_settled", early_settled,
          int'(!m_pending && seen > 0 && (int'(IW) - seen) <= int'(EPS)));
    end
  end

  task automatic step(input logic v, input logic b, input logic r);
    stream_valid = v;
    stream_bit   = b;
    result_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat;

    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    chk("rst result", result, 0);
    chk("rst valid", result_valid, 0);
    chk("rst upper", upper_bound, 8);
    chk("rst estimate", estimate, 4);
    chk("rst busy", busy, 0);
    chk("rst early", early_settled, 0);

    // All-ones frame
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b1);
      if (i == 6) chk("ones valid early", result_valid, 0);
    end
    chk("ones result", result, 8);
    chk("ones valid", result_valid, 1);
    chk("ones upper", upper_bound, 8);
    chk("ones lower", lower_bound, 8);
    step(1'b0, 1'b0, 1'b1);
    chk("ones idle busy", busy, 0);

    // Gapped frame 1,0,1,1,0,0,1,0
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pat[i], 1'b0);
      if (i == 4) begin
        chk("gap5 lower", lower_bound, 3);
        chk("gap5 early", early_settled, 0);
      end
      if (i == 5) begin
        chk("gap6 lower", lower_bound, 3);
        chk("gap6 upper", upper_bound, 5);
        chk("gap6 estimate", estimate, 4);
        chk("gap6 early", early_settled, 1);
      end
      if (i < 7) step(1'b0, 1'b0, 1'b0);
    end
    chk("gap result", result, 4);
    chk("gap hold early", early_settled, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // Back-to-back frames, 8 then 0
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1);
    chk("b2b first", result, 8);
    step(1'b1, 1'b0, 1'b1);
    chk("b2b handoff bits", bits_seen, 1);
    chk("b2b handoff valid", result_valid, 0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1);
    chk("b2b second", result, 0);
    chk("b2b second valid", result_valid, 1);
    chk("b2b dropped", dropped, 0);
    step(1'b0, 1'b0, 1'b1);

    // Backpressure with dropped bits
    for (int i = 0; i < 8; i++) step(1'b1, 1'(i % 2), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    chk("bp result", result, 4);
    chk("bp valid", result_valid, 1);
    chk("bp dropped", dropped, 1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    chk("bp next bits", bits_seen, 1);

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
    chk("midrst bits", bits_seen, 0);
    chk("midrst upper", upper_bound, 8);
    chk("midrst busy", busy, 0);
    chk("midrst dropped", dropped, 0);
    pat = 8'b1000_1011;
    for (int i = 0; i < 8; i++) step(1'b1, pat[i], 1'b0);
    chk("midrst result", result, 4);
    chk("midrst valid", result_valid, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
